// File: rtl/stepper_step_ctrl_if.sv
// Step-rate controller bus: motion request in, step pulse and status out.
// The master side requests motion; the slave side is the step controller.
interface stepper_step_ctrl_if #(
    parameter int CNT_W = 27
);
    logic             run;
    logic             dir_req;
    logic             step;
    logic             clockwise;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output run,
        output dir_req,
        input  step,
        input  clockwise,
        input  busy,
        input  cur_div
    );

    modport slave (
        input  run,
        input  dir_req,
        output step,
        output clockwise,
        output busy,
        output cur_div
    );
endinterface

// File: rtl/stepper_step_ctrl.sv
// Trapezoidal step-rate generator feeding the stepper phase FSM driver.
// Produces a one-cycle step enable on the free-running clock, ramping the
// step period from START_DIV down to MIN_DIV and back up before stopping.
// Direction is latched on launch and only changes from IDLE.
module stepper_step_ctrl #(
    parameter int CNT_W     = 27,
    parameter int START_DIV = 10000000,
    parameter int MIN_DIV   = 1000000,
    parameter int RAMP_STEP = 1500000
) (
    input  logic                clk,
    input  logic                reset,
    stepper_step_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEL  = 2'd1;
    localparam logic [1:0] CRUISE = 2'd2;
    localparam logic [1:0] DECEL  = 2'd3;

    localparam int DIV_MAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] START_D = CNT_W'(START_DIV);
    localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DIV);
    // A ramp step wider than the counter always saturates, so clamp it to
    // the largest representable value to keep all arithmetic in CNT_W bits.
    localparam logic [CNT_W-1:0] RAMP_SAT =
        CNT_W'((RAMP_STEP > DIV_MAX) ? DIV_MAX : RAMP_STEP);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             step_q, step_d;
    logic             cw_q, cw_d;

    logic             period_done;
    logic             stop_req;
    logic [CNT_W-1:0] div_accel;
    logic [CNT_W-1:0] div_decel;

    // Saturating next-period values; compare the headroom before adjusting
    // so neither the subtraction nor the addition can wrap.
    always_comb begin
        period_done = (cnt_q == div_q - CNT_W'(1));
        stop_req    = !bus.run || (bus.dir_req != cw_q);
        div_accel   = ((div_q - MIN_D) > RAMP_SAT) ? (div_q - RAMP_SAT) : MIN_D;
        div_decel   = ((START_D - div_q) > RAMP_SAT) ? (div_q + RAMP_SAT) : START_D;
    end

    // Next-state logic: period counter, ramp updates and FSM transitions.
    // A step-driven period update is applied first and a pending stop or
    // resume request then decides the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        step_d  = 1'b0;
        cw_d    = cw_q;

        if (state_q == IDLE) begin
            if (bus.run) begin
                cw_d    = bus.dir_req;
                cnt_d   = '0;
                div_d   = START_D;
                state_d = ACCEL;
            end
        end else begin
            if (period_done) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            case (state_q)
                ACCEL: begin
                    if (period_done) begin
                        div_d = div_accel;
                        if (div_accel == MIN_D) begin
                            state_d = CRUISE;
                        end
                    end
                    if (stop_req) begin
                        state_d = DECEL;
                    end
                end
                CRUISE: begin
                    if (stop_req) begin
                        state_d = DECEL;
                    end
                end
                DECEL: begin
                    if (period_done) begin
                        if (div_q == START_D) begin
                            state_d = IDLE;
                        end else begin
                            div_d = div_decel;
                        end
                    end
                    if (!stop_req) begin
                        state_d = ACCEL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over motion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= START_D;
            step_q  <= 1'b0;
            cw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            step_q  <= step_d;
            cw_q    <= cw_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.clockwise = cw_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.cur_div   = div_q;

endmodule

// File: tb/tb_stepper_step_ctrl.sv
// Directed bench for stepper_step_ctrl with a step-event scoreboard.
// Stimulus pushes the expected step cycle, direction and period; a monitor
// pops one entry for every step pulse it sees.
module tb_stepper_step_ctrl;

    localparam int CNT_W = 4;

    typedef struct {
        int         cyc;
        logic       cw;
        logic [3:0] div;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   check_count;
    int   fail_count;
    logic prev_step;
    exp_t exp_q[$];
    int   l1;
    int   l2;

    stepper_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    stepper_step_ctrl #(
        .CNT_W     (CNT_W),
        .START_DIV (8),
        .MIN_DIV   (2),
        .RAMP_STEP (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and cycle index; after the k-th rising edge cyc == k.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string name, input int act, input int req);
        check_count++;
        if (act != req) begin
            fail_count++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input logic busy_req,
                               input logic cw_req, input int div_req,
                               input logic step_req);
        checkVal({name, "_busy"}, int'(bus.busy), int'(busy_req));
        checkVal({name, "_cw"}, int'(bus.clockwise), int'(cw_req));
        checkVal({name, "_div"}, int'(bus.cur_div), div_req);
        checkVal({name, "_step"}, int'(bus.step), int'(step_req));
    endtask

    task automatic applyStimulus(input logic run, input logic dir);
        bus.run     = run;
        bus.dir_req = dir;
    endtask

    task automatic expectStep(input int c, input logic cw, input int div);
        exp_t e;
        e.cyc = c;
        e.cw  = cw;
        e.div = 4'(div);
        exp_q.push_back(e);
    endtask

    task automatic gotoCycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every step pulse is matched against the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.step === 1'b1) begin
            if (prev_step) begin
                check_count++;
                fail_count++;
                $display("[TB] FAIL step_back_to_back at cycle %0d: got 2 consecutive pulses, required 1", cyc);
            end
            if (exp_q.size() == 0) begin
                check_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_step at cycle %0d: got step=1, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                checkVal("step_cycle", cyc, e.cyc);
                checkVal("step_cw", int'(bus.clockwise), int'(e.cw));
                checkVal("step_div", int'(bus.cur_div), int'(e.div));
            end
        end
        prev_step = (bus.step === 1'b1);
    end

    initial begin
        check_count = 0;
        fail_count  = 0;
        prev_step   = 1'b0;
        reset       = 1'b1;
        applyStimulus(1'b0, 1'b1);

        // Reset held for two edges, then twenty idle cycles.
        @(negedge clk);
        gotoCycle(2);
        checkOutput("reset", 1'b0, 1'b1, 8, 1'b0);
        reset = 1'b0;
        gotoCycle(5);
        applyStimulus(1'b0, 1'b0);
        gotoCycle(10);
        checkOutput("idle_dir_toggle", 1'b0, 1'b1, 8, 1'b0);
        applyStimulus(1'b0, 1'b1);
        gotoCycle(22);
        checkOutput("idle", 1'b0, 1'b1, 8, 1'b0);

        // Acceleration profile into cruise, then stop right after a step.
        l1 = cyc + 1;
        applyStimulus(1'b1, 1'b1);
        expectStep(l1 + 8,  1'b1, 5);
        expectStep(l1 + 13, 1'b1, 2);
        expectStep(l1 + 15, 1'b1, 2);
        expectStep(l1 + 17, 1'b1, 2);
        expectStep(l1 + 19, 1'b1, 2);
        gotoCycle(l1 + 1);
        checkOutput("launch", 1'b1, 1'b1, 8, 1'b0);
        gotoCycle(l1 + 14);
        checkOutput("cruise", 1'b1, 1'b1, 2, 1'b0);
        gotoCycle(l1 + 19);
        applyStimulus(1'b0, 1'b1);
        expectStep(l1 + 21, 1'b1, 5);
        expectStep(l1 + 26, 1'b1, 8);
        expectStep(l1 + 34, 1'b1, 8);
        gotoCycle(l1 + 33);
        checkOutput("decel_busy", 1'b1, 1'b1, 8, 1'b0);
        gotoCycle(l1 + 35);
        checkOutput("decel_done", 1'b0, 1'b1, 8, 1'b0);
        gotoCycle(l1 + 40);

        // Reversal while cruising: stop, one idle cycle, relaunch counter-clockwise.
        l2 = cyc + 1;
        applyStimulus(1'b1, 1'b1);
        expectStep(l2 + 8,  1'b1, 5);
        expectStep(l2 + 13, 1'b1, 2);
        expectStep(l2 + 15, 1'b1, 2);
        gotoCycle(l2 + 15);
        applyStimulus(1'b1, 1'b0);
        expectStep(l2 + 17, 1'b1, 5);
        expectStep(l2 + 22, 1'b1, 8);
        expectStep(l2 + 30, 1'b1, 8);
        expectStep(l2 + 39, 1'b0, 5);
        expectStep(l2 + 44, 1'b0, 2);
        expectStep(l2 + 46, 1'b0, 2);
        expectStep(l2 + 48, 1'b0, 2);
        gotoCycle(l2 + 29);
        checkOutput("rev_decel", 1'b1, 1'b1, 8, 1'b0);
        gotoCycle(l2 + 30);
        checkOutput("rev_idle", 1'b0, 1'b1, 8, 1'b1);
        gotoCycle(l2 + 31);
        checkOutput("rev_launch", 1'b1, 1'b0, 8, 1'b0);

        // Decel abort: run low for three cycles, then resume without a speed jump.
        gotoCycle(l2 + 48);
        applyStimulus(1'b0, 1'b0);
        expectStep(l2 + 50, 1'b0, 5);
        expectStep(l2 + 55, 1'b0, 2);
        expectStep(l2 + 57, 1'b0, 2);
        expectStep(l2 + 59, 1'b0, 2);
        gotoCycle(l2 + 51);
        applyStimulus(1'b1, 1'b0);
        gotoCycle(l2 + 53);
        checkOutput("abort_resume", 1'b1, 1'b0, 5, 1'b0);

        // Reset one cycle before a due cruise step suppresses that step.
        gotoCycle(l2 + 60);
        reset = 1'b1;
        gotoCycle(l2 + 61);
        checkOutput("reset_mid", 1'b0, 1'b1, 8, 1'b0);
        reset = 1'b0;
        expectStep(l2 + 70, 1'b0, 5);
        expectStep(l2 + 75, 1'b0, 2);
        gotoCycle(l2 + 75);
        applyStimulus(1'b0, 1'b0);
        expectStep(l2 + 77, 1'b0, 5);
        expectStep(l2 + 82, 1'b0, 8);
        expectStep(l2 + 90, 1'b0, 8);
        gotoCycle(l2 + 95);
        checkOutput("final_idle", 1'b0, 1'b0, 8, 1'b0);

        checkVal("steps_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
